// File: rtl/multiply_writeback_unit.sv
// Sequential unsigned shift-add multiplier that writes its 2*WIDTH-bit product
// into two register-file entries, yielding the write port to the main datapath.
module multiply_writeback_unit #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   OperandA,
  input  logic [WIDTH-1:0]   OperandB,
  input  logic [AW-1:0]      DestLo,
  input  logic [AW-1:0]      DestHi,
  input  logic               ExtRegWrite,
  output logic [AW-1:0]      RD,
  output logic [WIDTH-1:0]   WriteData,
  output logic               RegWrite,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WR_LO,
    S_WR_HI
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      lo_q, lo_d;
  logic [AW-1:0]      hi_q, hi_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    product_d = product_q;
    done_d    = 1'b0;
    RD        = '0;
    WriteData = '0;
    RegWrite  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = {{WIDTH{1'b0}}, OperandA};
          mplier_d = OperandB;
          lo_d     = DestLo;
          hi_d     = DestHi;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Product is published on the same edge as the final accumulation.
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = acc_d;
          state_d   = S_WR_LO;
        end
      end
      S_WR_LO: begin
        RD        = lo_q;
        WriteData = acc_q[WIDTH-1:0];
        RegWrite  = !ExtRegWrite && (lo_q != '0) && !Reset;
        if (!ExtRegWrite) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        RD        = hi_q;
        WriteData = acc_q[2*WIDTH-1:WIDTH];
        RegWrite  = !ExtRegWrite && (hi_q != '0) && !Reset;
        if (!ExtRegWrite) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_multiply_writeback_unit.sv
// Randomized bench for multiply_writeback_unit: an arithmetic product model and
// a register-file scoreboard fed only by observed write-port activity.
module tb_multiply_writeback_unit;
  localparam int W  = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, ext;
  logic [W-1:0]  a, b;
  logic [AW-1:0] dlo, dhi;
  logic [AW-1:0] rd;
  logic [W-1:0]  wdata;
  logic          we, busy, done;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] rf     [16];
  logic [W-1:0] rf_exp [16];

  always #5 clk = ~clk;

  multiply_writeback_unit #(.WIDTH(W), .AW(AW)) dut (
    .Clock(clk), .Reset(rst), .Start(start),
    .OperandA(a), .OperandB(b), .DestLo(dlo), .DestHi(dhi),
    .ExtRegWrite(ext), .RD(rd), .WriteData(wdata), .RegWrite(we),
    .Busy(busy), .Done(done), .Product(product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic observe_write();
    if (we === 1'b1) rf[rd] = wdata;
  endtask

  task automatic check_rf();
    for (int i = 0; i < 16; i++) check($sformatf("rf%0d", i), 64'(rf[i]), 64'(rf_exp[i]));
  endtask

  task automatic idle_cycle(input bit exp_done);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; ext = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_done", 64'(done), 64'(exp_done));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_we", 64'(we), 64'(0));
    check("idle_rd", 64'(rd), 64'(0));
    observe_write();
  endtask

  // Cycle 0 drives Start; cycle k is the k-th cycle after the acceptance edge.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                        input int sl, input int sh, input bit prev_done);
    logic [63:0] p;
    int last;
    bit exp_we;
    p = {40'b0, oa} * {40'b0, ob};
    last = 26 + sl + sh;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; a = oa; b = ob; dlo = lo; dhi = hi;
    ext = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("accept_done", 64'(done), 64'(prev_done));
    check("accept_busy", 64'(busy), 64'(0));
    check("accept_we", 64'(we), 64'(0));
    observe_write();
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); dlo = AW'($urandom); dhi = AW'($urandom);
      if (k < 25)                ext = 1'($urandom_range(0, 1));
      else if (k < 25 + sl)      ext = 1'b1;
      else if (k == 25 + sl)     ext = 1'b0;
      else if (k < 26 + sl + sh) ext = 1'b1;
      else                       ext = 1'b0;
      @(negedge clk);
      exp_we = ((k == 25 + sl) && (lo != 0)) || ((k == last) && (hi != 0));
      check("busy", 64'(busy), 64'(1));
      check("done_low", 64'(done), 64'(0));
      check("we", 64'(we), 64'(exp_we));
      if (k == 25 + sl) begin
        check("rd_lo", 64'(rd), 64'(lo));
        check("wdata_lo", 64'(wdata), 64'(p[23:0]));
      end
      if (k == last) begin
        check("rd_hi", 64'(rd), 64'(hi));
        check("wdata_hi", 64'(wdata), 64'(p[47:24]));
      end
      observe_write();
    end
    check("product", 64'(product), p);
    if (lo != 0) rf_exp[lo] = p[23:0];
    if (hi != 0) rf_exp[hi] = p[47:24];
    check_rf();
  endtask

  task automatic reset_during(input logic [W-1:0] oa, input logic [W-1:0] ob,
                              input logic [AW-1:0] lo, input logic [AW-1:0] hi, input int kr);
    logic [63:0] p;
    p = {40'b0, oa} * {40'b0, ob};
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; a = oa; b = ob; dlo = lo; dhi = hi; ext = 1'b0;
    @(negedge clk);
    observe_write();
    for (int k = 1; k <= kr; k++) begin
      @(posedge clk); #1;
      start = 1'b0; ext = 1'b0;
      rst = (k == kr);
      @(negedge clk);
      if (k == kr) check("rst_we", 64'(we), 64'(0));
      observe_write();
    end
    if (kr > 25 && lo != 0) rf_exp[lo] = p[23:0];
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_we2", 64'(we), 64'(0));
    check("rst_rd", 64'(rd), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_product", 64'(product), 64'(0));
    observe_write();
    idle_cycle(1'b0);
    check_rf();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit chain;
    rst = 1'b1; start = 1'b0; ext = 1'b0; a = '0; b = '0; dlo = '0; dhi = '0;
    for (int i = 0; i < 16; i++) begin rf[i] = '0; rf_exp[i] = '0; end
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; ext = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_we", 64'(we), 64'(0));
    check("reset_rd", 64'(rd), 64'(0));
    check("reset_wdata", 64'(wdata), 64'(0));
    check("reset_product", 64'(product), 64'(0));
    idle_cycle(1'b0);

    run_op(24'd3, 24'd5, 4'd1, 4'd2, 0, 0, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_op(24'hFFFFFF, 24'hFFFFFF, 4'd3, 4'd4, 0, 0, 1'b0);
    idle_cycle(1'b1);
    run_op(24'h000100, 24'h000100, 4'd6, 4'd7, 3, 0, 1'b0);
    idle_cycle(1'b1);
    run_op(24'h800000, 24'd4, 4'd0, 4'd5, 0, 0, 1'b0);
    idle_cycle(1'b1);

    reset_during(24'd3, 24'd5, 4'd1, 4'd2, 10);
    run_op(24'd2, 24'd7, 4'd8, 4'd9, 0, 0, 1'b0);
    idle_cycle(1'b1);
    reset_during(24'h123456, 24'h654321, 4'd11, 4'd12, 25);
    reset_during(24'hABCDEF, 24'h13579B, 4'd13, 4'd14, 26);

    run_op(W'($urandom), W'($urandom), 4'd10, 4'd10, 1, 2, 1'b0);
    chain = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), AW'($urandom), AW'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), chain);
      chain = 1'($urandom_range(0, 1));
      if (!chain) idle_cycle(1'b1);
    end
    if (chain) idle_cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
